// File: rtl/load_store_unit_if.sv
// Core request/response and data-memory bus bundle for the load/store unit.
// master = core + memory side, slave = load_store_unit.
interface load_store_unit_if #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ADDRWIDTH = 32,
  parameter int unsigned BUSWIDTH  = 32
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [2:0]           req_funct3;
  logic [XLEN-1:0]      req_addr;
  logic [XLEN-1:0]      req_wdata;
  logic                 resp_valid;
  logic                 resp_err;
  logic [XLEN-1:0]      resp_rdata;
  logic [ADDRWIDTH-1:0] data_rd_addr;
  logic [BUSWIDTH-1:0]  data_rd_data;
  logic [ADDRWIDTH-1:0] data_wr_addr;
  logic [BUSWIDTH-1:0]  data_wr_data;
  logic                 data_wren;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, data_rd_data,
    input  req_ready, resp_valid, resp_err, resp_rdata,
           data_rd_addr, data_wr_addr, data_wr_data, data_wren
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, data_rd_data,
    output req_ready, resp_valid, resp_err, resp_rdata,
           data_rd_addr, data_wr_addr, data_wr_data, data_wren
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time, sub-word loads are extracted
// and extended, sub-word stores are read-modify-write against a word memory.
module load_store_unit #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ADDRWIDTH = 32,
  parameter int unsigned BUSWIDTH  = 32
) (
  input  logic              clk,
  input  logic              cpu_rst,
  load_store_unit_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_LD_DATA,
    S_ST_MERGE,
    S_WR,
    S_RESP
  } state_e;

  state_e               state_q, state_d;
  logic                 we_q, we_d;
  logic [2:0]           funct3_q, funct3_d;
  logic [ADDRWIDTH-1:0] addr_q, addr_d;
  logic [XLEN-1:0]      wdata_q, wdata_d;
  logic [XLEN-1:0]      rdata_q, rdata_d;
  logic                 err_q, err_d;

  logic                 req_err;
  logic [ADDRWIDTH-1:0] word_addr;
  logic [7:0]           ld_byte;
  logic [15:0]          ld_half;
  logic [XLEN-1:0]      ld_val;
  logic [BUSWIDTH-1:0]  st_merge;

  assign word_addr      = {addr_q[ADDRWIDTH-1:2], 2'b00};
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

  // Illegal funct3 or misaligned access, judged on the incoming request.
  always_comb begin
    req_err = 1'b0;
    case (bus.req_funct3[1:0])
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = bus.req_addr[0];
      2'b10:   req_err = |bus.req_addr[1:0];
      default: req_err = 1'b1;
    endcase
    if (bus.req_funct3[2] && (bus.req_we || bus.req_funct3[1])) begin
      req_err = 1'b1;
    end
  end

  // Load lane select and sign/zero extension.
  always_comb begin
    ld_byte = 8'h00;
    case (addr_q[1:0])
      2'd0:    ld_byte = bus.data_rd_data[7:0];
      2'd1:    ld_byte = bus.data_rd_data[15:8];
      2'd2:    ld_byte = bus.data_rd_data[23:16];
      default: ld_byte = bus.data_rd_data[31:24];
    endcase
    ld_half = addr_q[1] ? bus.data_rd_data[31:16] : bus.data_rd_data[15:0];
    case (funct3_q)
      3'b000:  ld_val = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_val = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b100:  ld_val = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  ld_val = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_val = XLEN'(bus.data_rd_data);
    endcase
  end

  // Sub-word store merge into the word just read back.
  always_comb begin
    st_merge = bus.data_rd_data;
    if (funct3_q[1:0] == 2'b00) begin
      case (addr_q[1:0])
        2'd0:    st_merge[7:0]   = wdata_q[7:0];
        2'd1:    st_merge[15:8]  = wdata_q[7:0];
        2'd2:    st_merge[23:16] = wdata_q[7:0];
        default: st_merge[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      st_merge[31:16] = wdata_q[15:0];
    end else begin
      st_merge[15:0] = wdata_q[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (cpu_rst) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Bus strobes are decoded from the state register; the write strobe is
  // additionally gated by reset so an aborted operation never writes.
  always_comb begin
    state_d          = state_q;
    we_d             = we_q;
    funct3_d         = funct3_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    rdata_d          = rdata_q;
    err_d            = err_q;
    bus.req_ready    = 1'b0;
    bus.resp_valid   = 1'b0;
    bus.data_rd_addr = '0;
    bus.data_wr_addr = '0;
    bus.data_wr_data = '0;
    bus.data_wren    = 1'b0;

    case (state_q)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          we_d     = bus.req_we;
          funct3_d = bus.req_funct3;
          addr_d   = ADDRWIDTH'(bus.req_addr);
          wdata_d  = bus.req_wdata;
          rdata_d  = '0;
          err_d    = req_err;
          if (req_err) begin
            state_d = S_RESP;
          end else if (bus.req_we && (bus.req_funct3[1:0] == 2'b10)) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        bus.data_rd_addr = word_addr;
        state_d          = we_q ? S_ST_MERGE : S_LD_DATA;
      end
      S_LD_DATA: begin
        rdata_d = ld_val;
        state_d = S_RESP;
      end
      S_ST_MERGE: begin
        bus.data_wren    = ~cpu_rst;
        bus.data_wr_addr = word_addr;
        bus.data_wr_data = st_merge;
        state_d          = S_RESP;
      end
      S_WR: begin
        bus.data_wren    = ~cpu_rst;
        bus.data_wr_addr = word_addr;
        bus.data_wr_data = BUSWIDTH'(wdata_q);
        state_d          = S_RESP;
      end
      S_RESP: begin
        bus.resp_valid = 1'b1;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
